am2901_microseq: RTL and testbench
==================================

// Module: am2901_microseq
// PURPOSE
//  Microprogram sequencer that issues the 9-bit opcode, A/B register addresses and D operand to the Am2901 datapath.
//  It is the instruction source for the slice controller, which decodes what this block issues.
//  It runs the 2910-style pipeline: microaddress out -> external comb. ROM -> microword -> pipeline reg -> datapath.
//  It branches on datapath status flags and provides call/return on a stack, a loop counter, and start/done handshake.
// PARAMETERS
//  ADDR_W       8   microaddress width; microword width UW = ADDR_W+27
//  STACK_DEPTH  4   subroutine stack entries
//  CNT_W        8   loop counter width (<= ADDR_W)
// PORTS
//  clk        in   1       rising-edge clock
//  reset_n    in   1       async active-low reset
//  start      in   1       one-cycle pulse; honoured only in IDLE or DONE
//  start_addr in   ADDR_W  first microaddress on start
//  uaddr      out  ADDR_W  microaddress to ROM (combinational)
//  uword      in   UW      ROM data for uaddr, same cycle
//  z,ovr,cn4,f3 in 1 each  datapath flags for the instruction currently in the pipe reg
//  i          out  9       opcode to datapath (pipe reg field)
//  a,b        out  4 each  register addresses (pipe reg field)
//  d          out  4       D operand (pipe reg field)
//  busy       out  1       high in RUN
//  done       out  1       high in DONE until next start
//  stack_err  out  1       sticky stack over/underflow; cleared by accepted start
// BEHAVIOUR
//  Microword: seq[UW-1:UW-3] cond[UW-4:UW-5] pol[UW-6] br[ADDR_W+20:21] i[20:12] a[11:8] b[7:4] d[3:0]
//  cond select: 0=z 1=ovr 2=cn4 3=f3; test = flag ^ pol
//  Reset: state IDLE; pipe = NOP word (i=9'b001_000_000, a=b=d=0, seq=CONT); upc=0, sp=0, cnt=0; busy=done=stack_err=0
//  NOP opcode (i[8:6]=001) performs no RAM or Q write; i/a/b/d carry NOP fields whenever state != RUN
//  FSM: IDLE --start--> RUN; RUN --HALT in pipe--> DONE; DONE --start--> RUN; start during RUN is ignored
//  IDLE/DONE: uaddr = start_addr. On an accepted start, the pipe loads uword, upc <= start_addr+1, stack_err <= 0
//  RUN: uaddr is computed from the pipe seq field and flags. At each edge, pipe <= uword and upc <= uaddr+1 (mod 2^ADDR_W)
//   0 CONT  uaddr=upc
//   1 JMP   uaddr=br
//   2 JCOND uaddr = test ? br : upc
//   3 CALL  push upc; uaddr=br. If full: no push, stack_err<=1, jump still taken
//   4 RET   uaddr=top; pop. If empty: uaddr=upc, stack_err<=1
//   5 LDCNT cnt<=br[CNT_W-1:0]; uaddr=upc
//   6 RPCT  cnt!=0: cnt<=cnt-1, uaddr=br; cnt==0: uaddr=upc, cnt stays 0
//   7 HALT  uaddr=upc. Next edge: state DONE, pipe <= NOP word, done<=1, busy<=0
//  Latency: a start pulse at edge k puts the first microword on i/a/b/d after edge k; one microword per cycle, no bubbles on branch
//  Each flag is consumed in the same cycle as its instruction; the flag path is comb from pipe -> datapath -> uaddr
//  upc, the counter and the stack wrap at their widths. The stack is not cleared by start; sp resets only on reset_n
//  reset_n low mid-run: all state returns to reset values asynchronously. Execution does not resume
// TESTING
//  1 reset; start_addr=8'h10, ROM 10:CONT,11:CONT,12:HALT -> uaddr 10,11,12, then 13; done=1 in cycle 4; i=NOP after
//  2 JCOND cond=z pol=0 br=8'h40: z=1 -> uaddr=40; z=0 -> uaddr=upc; with pol=1 the outcomes invert
//  3 LDCNT br=3 then RPCT br=self -> RPCT word issued 4 times (cnt 3,2,1,0), then falls through
//  4 nested CALL x4 then RET x4 -> correct return order; 5th CALL sets stack_err and still jumps; extra RET -> upc, stack_err=1
//  5 reset_n low mid-loop -> i=NOP, busy=0, sp=cnt=0 immediately; start during RUN is ignored; start in DONE clears stack_err

Source files
------------

// File: rtl/am2901_microseq.sv
// Microprogram sequencer for an Am2901 datapath: 2910-style next-address logic,
// a one-word pipeline register, a call/return stack and a loop counter.
module am2901_microseq #(
    parameter  int ADDR_W      = 8,
    parameter  int STACK_DEPTH = 4,
    parameter  int CNT_W       = 8,
    localparam int UW          = ADDR_W + 27,
    localparam int SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] uaddr,
    input  logic [UW-1:0]     uword,
    input  logic              z,
    input  logic              ovr,
    input  logic              cn4,
    input  logic              f3,
    output logic [8:0]        i,
    output logic [3:0]        a,
    output logic [3:0]        b,
    output logic [3:0]        d,
    output logic              busy,
    output logic              done,
    output logic              stack_err,
    output logic [1:0]        dbg_state,
    output logic [SP_W-1:0]   dbg_sp,
    output logic [CNT_W-1:0]  dbg_cnt
);

    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [2:0] SEQ_CONT  = 3'd0;
    localparam logic [2:0] SEQ_JMP   = 3'd1;
    localparam logic [2:0] SEQ_JCOND = 3'd2;
    localparam logic [2:0] SEQ_CALL  = 3'd3;
    localparam logic [2:0] SEQ_RET   = 3'd4;
    localparam logic [2:0] SEQ_LDCNT = 3'd5;
    localparam logic [2:0] SEQ_RPCT  = 3'd6;
    localparam logic [2:0] SEQ_HALT  = 3'd7;

    localparam logic [UW-1:0] NOP_WORD = {{(ADDR_W + 6){1'b0}}, 9'b001_000_000, 12'h000};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state, state_next;
    logic [UW-1:0]       pipe;
    logic [ADDR_W-1:0]   upc;
    logic [SP_W-1:0]     sp;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_W-1:0]   stack_mem [STACK_DEPTH];

    logic [2:0]          seq;
    logic [1:0]          cond;
    logic                pol;
    logic [ADDR_W-1:0]   br;
    logic                flag;
    logic                test;
    logic [SP_W-1:0]     sp_dec;
    logic [ADDR_W-1:0]   top;
    logic                stack_full;
    logic                stack_empty;

    logic                push;
    logic                pop;
    logic                cnt_load;
    logic                cnt_dec;
    logic                err_set;
    logic                accept;

    assign seq         = pipe[UW-1:UW-3];
    assign cond        = pipe[UW-4:UW-5];
    assign pol         = pipe[UW-6];
    assign br          = pipe[ADDR_W+20:21];
    assign i           = pipe[20:12];
    assign a           = pipe[11:8];
    assign b           = pipe[7:4];
    assign d           = pipe[3:0];

    assign sp_dec      = sp - SP_W'(1);
    assign top         = stack_mem[sp_dec[IDX_W-1:0]];
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    assign busy        = (state == ST_RUN);
    assign done        = (state == ST_DONE);
    assign dbg_state   = state;
    assign dbg_sp      = sp;
    assign dbg_cnt     = cnt;

    // Start handshake: start is a one-cycle request with no ready; it is
    // accepted only when the FSM is in IDLE or DONE and silently dropped in RUN.
    assign accept      = start && (state != ST_RUN);

    always_comb begin
        case (cond)
            2'd0:    flag = z;
            2'd1:    flag = ovr;
            2'd2:    flag = cn4;
            default: flag = f3;
        endcase
        test = flag ^ pol;
    end

    // Next-address logic: flags arrive combinationally for the word in the pipe
    always_comb begin
        state_next = state;
        uaddr      = start_addr;
        push       = 1'b0;
        pop        = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        err_set    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (accept) state_next = ST_RUN;
            end
            ST_RUN: begin
                uaddr = upc;
                case (seq)
                    SEQ_JMP:   uaddr = br;
                    SEQ_JCOND: uaddr = test ? br : upc;
                    SEQ_CALL: begin
                        uaddr = br;
                        if (stack_full) err_set = 1'b1;
                        else            push    = 1'b1;
                    end
                    SEQ_RET: begin
                        if (stack_empty) begin
                            err_set = 1'b1;
                        end else begin
                            uaddr = top;
                            pop   = 1'b1;
                        end
                    end
                    SEQ_LDCNT: cnt_load = 1'b1;
                    SEQ_RPCT: begin
                        if (cnt != '0) begin
                            uaddr   = br;
                            cnt_dec = 1'b1;
                        end
                    end
                    SEQ_HALT:  state_next = ST_DONE;
                    default:   uaddr = upc;
                endcase
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            pipe      <= NOP_WORD;
            upc       <= '0;
            sp        <= '0;
            cnt       <= '0;
            stack_err <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_RUN) begin
                pipe <= (seq == SEQ_HALT) ? NOP_WORD : uword;
                upc  <= uaddr + ADDR_W'(1);
                if (push)     sp        <= sp + SP_W'(1);
                if (pop)      sp        <= sp_dec;
                if (cnt_load) cnt       <= br[CNT_W-1:0];
                if (cnt_dec)  cnt       <= cnt - CNT_W'(1);
                if (err_set)  stack_err <= 1'b1;
            end else if (accept) begin
                pipe      <= uword;
                upc       <= uaddr + ADDR_W'(1);
                stack_err <= 1'b0;
            end
        end
    end

    // Stack contents survive start; only sp is reset
    always_ff @(posedge clk) begin
        if (push) stack_mem[sp[IDX_W-1:0]] <= upc;
    end

endmodule

// File: tb/tb_am2901_microseq.sv
// Directed bench for am2901_microseq: a behavioural ROM array feeds uword,
// hand-computed microaddress sequences are checked through one task.
module tb_am2901_microseq;

    localparam logic [2:0] CONT = 3'd0, JMP = 3'd1, JCOND = 3'd2, CALL = 3'd3;
    localparam logic [2:0] RET = 3'd4, LDCNT = 3'd5, RPCT = 3'd6, HALT = 3'd7;
    localparam logic [8:0] NOP_I = 9'b001_000_000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [7:0]  uaddr;
    logic [34:0] uword;
    logic        z = 1'b0, ovr = 1'b0, cn4 = 1'b0, f3 = 1'b0;
    logic [8:0]  i;
    logic [3:0]  a, b, d;
    logic        busy, done, stack_err;
    logic [1:0]  dbg_state;
    logic [2:0]  dbg_sp;
    logic [7:0]  dbg_cnt;

    logic [34:0] rom [256];
    logic [7:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail = 0;

    assign uword = rom[uaddr];

    am2901_microseq dut (
        .clk(clk), .reset_n(reset_n), .start(start), .start_addr(start_addr),
        .uaddr(uaddr), .uword(uword), .z(z), .ovr(ovr), .cn4(cn4), .f3(f3),
        .i(i), .a(a), .b(b), .d(d), .busy(busy), .done(done), .stack_err(stack_err),
        .dbg_state(dbg_state), .dbg_sp(dbg_sp), .dbg_cnt(dbg_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic logic [34:0] mkw(input logic [2:0] seq, input logic [1:0] cond,
                                        input logic pol, input logic [7:0] br,
                                        input logic [7:0] at);
        logic [8:0] op;
        op = 9'h100 | {1'b0, at};
        return {seq, cond, pol, br, op, at[3:0], ~at[3:0], at[7:4]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [7:0] addr);
        start_addr = addr;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic set_flags(input logic [3:0] f);
        {f3, cn4, ovr, z} = f;
        #1;
    endtask

    task automatic run_to_done();
        int n = 0;
        while (!done && n < 20) begin
            step();
            n++;
        end
        check("done_reached", done, 1);
        set_flags(4'b0000);
    endtask

    task automatic jcond_case(input logic [7:0] addr, input logic [3:0] f_a,
                              input logic [7:0] exp_a, input logic [3:0] f_b,
                              input logic [7:0] exp_b);
        do_start(addr);
        set_flags(f_a);
        check("jcond_a", uaddr, exp_a);
        set_flags(f_b);
        check("jcond_b", uaddr, exp_b);
        run_to_done();
    endtask

    initial begin
        int rpct_seen;
        logic [7:0] e;
        for (int k = 0; k < 256; k++) rom[k] = mkw(HALT, 2'd0, 1'b0, 8'h00, 8'(k));
        rom[8'h10] = mkw(CONT, 2'd0, 1'b0, 8'h00, 8'h10);
        rom[8'h11] = mkw(CONT, 2'd0, 1'b0, 8'h00, 8'h11);
        rom[8'h30] = mkw(JCOND, 2'd0, 1'b0, 8'h40, 8'h30);
        rom[8'h34] = mkw(JCOND, 2'd0, 1'b1, 8'h40, 8'h34);
        rom[8'h38] = mkw(JCOND, 2'd3, 1'b0, 8'h44, 8'h38);
        rom[8'h3A] = mkw(JCOND, 2'd1, 1'b0, 8'h44, 8'h3A);
        rom[8'h3C] = mkw(JCOND, 2'd2, 1'b1, 8'h44, 8'h3C);
        rom[8'h20] = mkw(LDCNT, 2'd0, 1'b0, 8'h03, 8'h20);
        rom[8'h21] = mkw(RPCT, 2'd0, 1'b0, 8'h21, 8'h21);
        rom[8'h50] = mkw(CALL, 2'd0, 1'b0, 8'h60, 8'h50);
        rom[8'h60] = mkw(CALL, 2'd0, 1'b0, 8'h70, 8'h60);
        rom[8'h70] = mkw(CALL, 2'd0, 1'b0, 8'h80, 8'h70);
        rom[8'h80] = mkw(CALL, 2'd0, 1'b0, 8'h90, 8'h80);
        rom[8'h90] = mkw(CALL, 2'd0, 1'b0, 8'hA0, 8'h90);
        rom[8'hA0] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'hA0);
        rom[8'h81] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'h81);
        rom[8'h71] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'h71);
        rom[8'h61] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'h61);
        rom[8'h51] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'h51);
        rom[8'hB0] = mkw(RET, 2'd0, 1'b0, 8'h00, 8'hB0);
        rom[8'hC0] = mkw(CALL, 2'd0, 1'b0, 8'hD0, 8'hC0);
        rom[8'hD0] = mkw(LDCNT, 2'd0, 1'b0, 8'h05, 8'hD0);
        rom[8'hD1] = mkw(RPCT, 2'd0, 1'b0, 8'hD1, 8'hD1);

        // 1: reset state and straight-line run
        start_addr = 8'h10;
        #12;
        check("rst_i", i, NOP_I);
        check("rst_abd", {a, b, d}, 12'h000);
        check("rst_flags", {busy, done, stack_err}, 3'b000);
        check("rst_sp_cnt", {dbg_sp, dbg_cnt}, 11'h000);
        check("idle_uaddr", uaddr, 8'h10);
        reset_n = 1'b1;
        step();
        check("idle_hold", {busy, i}, {1'b0, NOP_I});
        do_start(8'h10);
        check("t1_i", i, 9'h110);
        check("t1_abd", {a, b, d}, 12'h0F1);
        check("t1_busy", busy, 1);
        check("t1_ua11", uaddr, 8'h11);
        step();
        check("t1_ua12", uaddr, 8'h12);
        step();
        check("t1_ua13", uaddr, 8'h13);
        check("t1_halt_busy", {busy, done}, 2'b10);
        step();
        check("t1_done", {busy, done}, 2'b01);
        check("t1_nop", i, NOP_I);
        check("t1_done_uaddr", uaddr, 8'h10);
        step();
        check("t1_done_hold", {done, i}, {1'b1, NOP_I});

        // 2: conditional branches; flags as {f3,cn4,ovr,z}
        jcond_case(8'h30, 4'b0001, 8'h40, 4'b0000, 8'h31);
        jcond_case(8'h34, 4'b0001, 8'h35, 4'b0000, 8'h40);
        jcond_case(8'h38, 4'b0001, 8'h39, 4'b1000, 8'h44);
        jcond_case(8'h3A, 4'b0010, 8'h44, 4'b0100, 8'h3B);
        jcond_case(8'h3C, 4'b0100, 8'h3D, 4'b0000, 8'h44);

        // 3: loop counter
        do_start(8'h20);
        check("t3_ld_ua", uaddr, 8'h21);
        step();
        exp_q = '{8'h03, 8'h02, 8'h01, 8'h00};
        rpct_seen = 0;
        for (int n = 0; n < 12 && !done; n++) begin
            if (i == 9'h121) begin
                rpct_seen++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
                check("t3_cnt", dbg_cnt, e);
                check("t3_ua", uaddr, (e != 0) ? 8'h21 : 8'h22);
            end
            step();
        end
        check("t3_rpct_count", rpct_seen, 4);
        check("t3_done", done, 1);

        // 4: nested calls, overflow, returns, underflow
        do_start(8'h50);
        exp_q = '{8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'h81, 8'h71, 8'h61, 8'h51, 8'h52, 8'h53};
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("t4_ua", uaddr, e);
            if (e == 8'hA0) check("t4_pre_ovf", {stack_err, 1'b0, dbg_sp}, 5'b0_0100);
            if (e == 8'h81) check("t4_ovf", {stack_err, 1'b0, dbg_sp}, 5'b1_0100);
            step();
        end
        check("t4_done", {done, stack_err, 1'b0, dbg_sp}, 6'b11_0000);
        do_start(8'hB0);
        check("t4_start_clr", stack_err, 0);
        check("t4_unf_ua", uaddr, 8'hB1);
        step();
        check("t4_unf_err", {stack_err, dbg_sp}, 4'b1000);
        run_to_done();

        // 5: start ignored in RUN, async reset mid-loop
        do_start(8'hC0);
        step();
        step();
        step();
        check("t5_loop", {dbg_sp, dbg_cnt}, {3'd1, 8'h04});
        start_addr = 8'h10;
        start = 1'b1;
        #1;
        check("t5_ign_ua", uaddr, 8'hD1);
        step();
        start = 1'b0;
        check("t5_ign_run", {busy, i}, {1'b1, 9'h1D1});
        check("t5_ign_cnt", dbg_cnt, 8'h03);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_i", i, NOP_I);
        check("t5_rst_busy", {busy, done, stack_err}, 3'b000);
        check("t5_rst_sp_cnt", {dbg_sp, dbg_cnt}, 11'h000);
        check("t5_rst_ua", uaddr, 8'h10);
        #3;
        reset_n = 1'b1;
        step();
        step();
        check("t5_no_resume", {busy, done, dbg_state}, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
